// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshakes on both sides.
//
// Operations: AND, OR, XOR, ADD, SUB, SLT, SLTU, SLL, SRL, SRA and an
// iterative shift-add MUL. The MUL is optional and controlled by MUL_EN.
// Non-MUL ops finish in one edge. MUL takes WIDTH edges.
// The result stays registered until the consumer takes it.
//
// Parameters:
//   WIDTH   operand/result width (>= 4, power of two)
//   SHW     shift-amount width, derived from WIDTH
//   MUL_EN  1 = MUL opcode legal, 0 = MUL is treated as illegal
//
// Ports:
//   clk        clock, posedge
//   rst        synchronous active-high reset
//   in_valid   operand bundle valid
//   in_ready   block can accept the bundle this cycle
//   a, b       operands; b[SHW-1:0] is the shift amount
//   sel        opcode
//   out_valid  registered result valid
//   out_ready  consumer accepts the result this cycle
//   out        registered result
//   zero, negative, carry, overflow, illegal  registered result flags
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 HOLD), for observation
//
// Handshake: a transfer happens on a posedge where valid and ready are
// both high. This applies to both sides. A producer holding valid keeps
// its data stable until that edge. in_ready may depend combinationally on
// out_ready, so a held result and a new operand can swap on the same edge.
// out_valid and the result fields are pure register outputs.

module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int SHW    = $clog2(WIDTH),
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state;

  // Registered outputs
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             negative_q;
  logic             carry_q;
  logic             overflow_q;
  logic             illegal_q;

  // Iterative multiplier datapath
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_next;
  logic             mul_last;

  // Handshake
  logic accept;
  logic is_mul;

  // Single-cycle ALU results
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_ill;
  logic             alu_zero;
  logic             alu_neg;

  // ------------------------------------------------------------------
  // Handshake logic
  // ------------------------------------------------------------------
  // A held result that is being taken this cycle frees the output
  // register. A new bundle can then be accepted on the same edge.
  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_HOLD);
  assign dbg_state = state;

  // With MUL_EN=0 the MUL opcode goes down the single-cycle path.
  // There it is flagged illegal like any other undefined code.
  assign is_mul = MUL_EN && (sel == OP_MUL);

  // ------------------------------------------------------------------
  // Single-cycle ALU
  // ------------------------------------------------------------------
  assign add_sum = {1'b0, a} + {1'b0, b};
  // The carry-out of a + ~b + 1 is the unsigned "no borrow" (a >= b) flag.
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt   = b[SHW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (sel)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res   = sub_sum[WIDTH-1:0];
        alu_carry = sub_sum[WIDTH];
        alu_ovf   = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      // When MUL is enabled it is handled by the BUSY path, and this
      // result is never registered.
      OP_MUL:  alu_ill = !MUL_EN;
      default: alu_ill = 1'b1;
    endcase
  end

  // An illegal op leaves alu_res at zero, so zero=1 and negative=0 follow.
  assign alu_zero = (alu_res == '0);
  assign alu_neg  = alu_res[MSB];

  // ------------------------------------------------------------------
  // Multiplier step
  // ------------------------------------------------------------------
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == {SHW{1'b1}});

  // ------------------------------------------------------------------
  // FSM and result registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      out_q      <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_BUSY;
            end else begin
              out_q      <= alu_res;
              zero_q     <= alu_zero;
              negative_q <= alu_neg;
              carry_q    <= alu_carry;
              overflow_q <= alu_ovf;
              illegal_q  <= alu_ill;
              state      <= S_HOLD;
            end
          end else if ((state == S_HOLD) && out_ready) begin
            // Result taken and nothing new arrived.
            state <= S_IDLE;
          end
        end

        S_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + {{(SHW-1){1'b0}}, 1'b1};
          if (mul_last) begin
            // The WIDTH-th step folds in the last partial product.
            // acc_next is the final low-half product.
            out_q      <= acc_next;
            zero_q     <= (acc_next == '0);
            negative_q <= acc_next[MSB];
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            state      <= S_HOLD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign out      = out_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (MUL enabled) ----------------
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, out;
  logic [3:0]   sel;
  logic         zero, negative, carry, overflow, illegal;
  logic [1:0]   dbg_state;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .illegal(illegal), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (MUL disabled) ----------------
  logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [W-1:0] n_a, n_b, n_out;
  logic [3:0]   n_sel;
  logic         n_zero, n_negative, n_carry, n_overflow, n_illegal;
  logic [1:0]   n_dbg_state;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nomul (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .sel(n_sel),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out(n_out), .zero(n_zero), .negative(n_negative), .carry(n_carry),
    .overflow(n_overflow), .illegal(n_illegal), .dbg_state(n_dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {illegal, overflow, carry, negative, zero, out}
  logic [W+4:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model built on 64-bit arithmetic.
  function automatic logic [W+4:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                         input logic [3:0] ss, input bit mul_en);
    logic [63:0]  wide;
    logic [W-1:0] r;
    logic         c, v, ill;
    longint       sa, sb, s;
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    case (ss)
      4'd0: r = aa & bb;
      4'd1: r = aa | bb;
      4'd2: r = aa ^ bb;
      4'd3: begin
        wide = {32'b0, aa} + {32'b0, bb};
        r = wide[W-1:0]; c = wide[W];
        s = sa + sb; v = (s != longint'($signed(r)));
      end
      4'd4: begin
        r = aa - bb; c = (aa >= bb);
        s = sa - sb; v = (s != longint'($signed(r)));
      end
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (aa < bb) ? 32'd1 : 32'd0;
      4'd7: r = aa << bb[4:0];
      4'd8: r = aa >> bb[4:0];
      4'd9: begin
        wide = {{32{aa[W-1]}}, aa} >> bb[4:0];
        r = wide[W-1:0];
      end
      4'd10: begin
        if (mul_en) begin
          wide = {32'b0, aa} * {32'b0, bb};
          r = wide[W-1:0];
        end else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    return {ill, v, c, r[W-1], (r == '0), r};
  endfunction

  // ---------------- driver tasks ----------------
  // Starts just after a negedge. Returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic [3:0] ss, output bit ok);
    int n;
    a = aa; b = bb; sel = ss; in_valid = 1'b1;
    exp_q.push_back(model(aa, bb, ss, 1'b1));
    ok = 1'b0; n = 0;
    while (!ok && n < 200) begin
      #1 ok = in_ready;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    a = '0; b = '0; sel = '0; n_a = '0; n_b = '0; n_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out: got %h exp 0", out); end
    checks++;
    if ({zero, negative, carry, overflow, illegal} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b exp 00000", {zero, negative, carry, overflow, illegal}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    @(negedge clk);
  endtask

  task automatic test_add;
    logic [W-1:0] ta[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] tb[2] = '{32'h1, 32'h1};
    logic [W+3:0] lit[2] = '{{4'b1010, 32'h8000_0000},   // {ovf,carry,neg,zero}
                            {4'b0101, 32'h0}};
    logic [W+4:0] exp, got;
    bit ok;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      send(ta[i], tb[i], 4'b0011, ok);
      wait_valid(4, cyc);
      checks++;
      if (!ok || !out_valid) begin errors++; $display("FAIL add_handshake[%0d]: accepted %b valid %b", i, ok, out_valid); end
      checks++;
      if (cyc !== 0) begin errors++; $display("FAIL add_latency[%0d]: got %0d exp 0", i, cyc); end
      checks++;
      if ({overflow, carry, negative, zero, out} !== lit[i])
        begin errors++; $display("FAIL add_literal[%0d]: got %h exp %h", i, {overflow, carry, negative, zero, out}, lit[i]); end
      got = {illegal, overflow, carry, negative, zero, out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL add_sb[%0d]: got %h exp %h", i, got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_sub_cmp;
    logic [W-1:0] ta[4]  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] tb[4]  = '{32'd7, 32'd1, 32'd1, 32'h24};
    logic [3:0]   ts[4]  = '{4'b0100, 4'b0101, 4'b0110, 4'b1001};
    logic [W-1:0] lit[4] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hF800_0000};
    logic [W+4:0] exp, got;
    bit ok;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], ts[i], ok);
      wait_valid(4, cyc);
      checks++;
      if (!ok || !out_valid) begin errors++; $display("FAIL subcmp_handshake[%0d]: accepted %b valid %b", i, ok, out_valid); end
      checks++;
      if (out !== lit[i]) begin errors++; $display("FAIL subcmp_literal[%0d]: got %h exp %h", i, out, lit[i]); end
      got = {illegal, overflow, carry, negative, zero, out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL subcmp_sb[%0d]: got %h exp %h", i, got, exp); end
    end
    // SUB 5-7 borrows: carry=0, negative=1
    checks++;
    @(negedge clk);
    send(32'd5, 32'd7, 4'b0100, ok);
    if ({carry, negative} !== 2'b01) begin errors++; $display("FAIL sub_flags: got %b exp 01", {carry, negative}); end
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_mul;
    logic [W-1:0] ta[2]  = '{32'h0001_2345, 32'hFFFF_FFFF};
    logic [W-1:0] tb[2]  = '{32'h0000_0100, 32'hFFFF_FFFF};
    logic [W-1:0] lit[2] = '{32'h0123_4500, 32'h0000_0001};
    logic [W+4:0] exp, got;
    bit ok;
    int cyc, ready_hi;
    for (int i = 0; i < 2; i++) begin
      send(ta[i], tb[i], 4'b1010, ok);
      cyc = 0; ready_hi = 0;
      while (!out_valid && cyc < 100) begin
        #1 if (in_ready) ready_hi++;
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (!ok || !out_valid) begin errors++; $display("FAIL mul_handshake[%0d]: accepted %b valid %b", i, ok, out_valid); end
      checks++;
      if (cyc !== 32) begin errors++; $display("FAIL mul_latency[%0d]: got %0d exp 32", i, cyc); end
      checks++;
      if (ready_hi !== 0) begin errors++; $display("FAIL mul_in_ready[%0d]: high %0d cycles exp 0", i, ready_hi); end
      checks++;
      if (out !== lit[i]) begin errors++; $display("FAIL mul_literal[%0d]: got %h exp %h", i, out, lit[i]); end
      got = {illegal, overflow, carry, negative, zero, out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL mul_sb[%0d]: got %h exp %h", i, got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [W+4:0] snap, exp, got;
    bit ok;
    int bad;
    out_ready = 1'b0;
    send(32'hF0F0_1234, 32'h0FF0_FF00, 4'b0000, ok);
    snap = {illegal, overflow, carry, negative, zero, out};
    // Present a competing bundle; it must be ignored.
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sel = 4'b0010; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {illegal, overflow, carry, negative, zero, out} !== snap) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_stall: %0d unstable cycles exp 0", bad); end
    got = {illegal, overflow, carry, negative, zero, out};
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL bp_sb: got %h exp %h", got, exp); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0)
      begin errors++; $display("FAIL bp_not_consumed: out_valid %b state %0d exp 0/0", out_valid, dbg_state); end
  endtask

  task automatic test_stream;
    logic [W+4:0] exp, got;
    logic [W-1:0] ra, rb;
    int bad_ready;
    out_ready = 1'b1; bad_ready = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b exp 1", i - 1, out_valid); end
        got = {illegal, overflow, carry, negative, zero, out};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL stream_sb[%0d]: got %h exp %h", i - 1, got, exp); end
      end
      if (i < 8) begin
        ra = $urandom; rb = $urandom;
        a = ra; b = rb; sel = 4'b0010; in_valid = 1'b1;
        exp_q.push_back(model(ra, rb, 4'b0010, 1'b1));
        #1 if (!in_ready) bad_ready++;
      end else in_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL stream_in_ready: low %0d cycles exp 0", bad_ready); end
  endtask

  task automatic test_random;
    logic [W+4:0] exp, got;
    logic [W-1:0] ra, rb;
    logic [3:0] rs;
    bit ok;
    int cyc;
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rs = 4'($urandom_range(0, 15));
      send(ra, rb, rs, ok);
      wait_valid(40, cyc);
      got = {illegal, overflow, carry, negative, zero, out};
      exp = exp_q.pop_front();
      checks++;
      if (!ok || !out_valid || got !== exp)
        begin errors++; $display("FAIL random[%0d] sel=%0d: got %h exp %h valid %b", i, rs, got, exp, out_valid); end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic [W+4:0] exp, got;
    bit ok;
    int cyc;
    send(32'h1234_5678, 32'h9ABC_DEF0, 4'b1100, ok);
    wait_valid(4, cyc);
    checks++;
    if (!out_valid || out !== '0 || illegal !== 1'b1 || zero !== 1'b1)
      begin errors++; $display("FAIL illegal_literal: valid %b out %h ill %b zero %b exp 1/0/1/1", out_valid, out, illegal, zero); end
    got = {illegal, overflow, carry, negative, zero, out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL illegal_sb: got %h exp %h", got, exp); end
    @(negedge clk);
    // MUL on the instance without a multiplier
    n_a = 32'd3; n_b = 32'd4; n_sel = 4'b1010; n_in_valid = 1'b1;
    exp = model(32'd3, 32'd4, 4'b1010, 1'b0);
    @(negedge clk);
    n_in_valid = 1'b0;
    checks++;
    if (n_out_valid !== 1'b1 || n_illegal !== 1'b1 || n_out !== '0 || n_zero !== 1'b1)
      begin errors++; $display("FAIL nomul_literal: valid %b ill %b out %h zero %b exp 1/1/0/1", n_out_valid, n_illegal, n_out, n_zero); end
    got = {n_illegal, n_overflow, n_carry, n_negative, n_zero, n_out};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL nomul_sb: got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    bit ok, seen;
    send(32'h0001_2345, 32'h0000_0100, 4'b1010, ok);
    exp_q.delete();  // the result is to be discarded by reset
    repeat (9) @(negedge clk);
    checks++;
    if (!ok || dbg_state !== 2'd1) begin errors++; $display("FAIL abort_busy: state %0d exp 1", dbg_state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      #1 if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_output: out_valid seen %b exp 0", seen); end
    checks++;
    if (dbg_state !== 2'd0 || in_ready !== 1'b1 || out !== '0)
      begin errors++; $display("FAIL abort_idle: state %0d in_ready %b out %h exp 0/1/0", dbg_state, in_ready, out); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_backpressure();
    test_stream();
    test_random();
    test_illegal();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
